// File: rtl/bus_arbiter_if.sv
// Signal bundle for the two-master data-bus arbiter: both master ports plus the Bridge side.
interface bus_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [BW-1:0] m0_byteen;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [BW-1:0] m1_byteen;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [BW-1:0] bus_byteen;
  logic [DW-1:0] bus_rdata;

  // Arbiter view
  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_byteen,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_byteen,
    output m1_gnt, m1_rvalid, m1_rdata,
    output bus_valid, bus_addr, bus_wdata, bus_byteen,
    input  bus_rdata
  );

  // Environment view (masters and Bridge)
  modport master (
    output m0_req, m0_addr, m0_wdata, m0_byteen,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_byteen,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  bus_valid, bus_addr, bus_wdata, bus_byteen,
    output bus_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the Bridge data bus: one transaction at a time, LAT bus cycles each.
// Define BUS_ARB_RR_EN for round-robin tie-break; default is fixed priority to M0.
module bus_arbiter #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 4
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bif
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam logic        M1 = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic           owner, owner_nx;
  logic           valid_q, valid_nx;
  logic [AW-1:0]  addr_q, addr_nx;
  logic [DW-1:0]  wdata_q, wdata_nx;
  logic [BW-1:0]  byteen_q, byteen_nx;
  logic           rvalid0_q, rvalid0_nx;
  logic           rvalid1_q, rvalid1_nx;
  logic [DW-1:0]  rdata0_q, rdata0_nx;
  logic [DW-1:0]  rdata1_q, rdata1_nx;
  logic           gnt0, gnt1;
  logic           pick1;

  // owner also serves as last_owner for the round-robin tie-break
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= M1;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byteen_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      owner     <= owner_nx;
      valid_q   <= valid_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      byteen_q  <= byteen_nx;
      rvalid0_q <= rvalid0_nx;
      rvalid1_q <= rvalid1_nx;
      rdata0_q  <= rdata0_nx;
      rdata1_q  <= rdata1_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    owner_nx   = owner;
    valid_nx   = valid_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    byteen_nx  = byteen_q;
    rvalid0_nx = 1'b0;
    rvalid1_nx = 1'b0;
    rdata0_nx  = rdata0_q;
    rdata1_nx  = rdata1_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

`ifdef BUS_ARB_RR_EN
    pick1 = bif.m1_req && (!bif.m0_req || owner != M1);
`else
    pick1 = bif.m1_req && !bif.m0_req;
`endif

    unique case (state)
      IDLE: begin
        if (!reset) begin
          gnt0 = bif.m0_req && !pick1;
          gnt1 = pick1;
        end
        if (gnt0 || gnt1) begin
          state_nx  = BUSY;
          cnt_nx    = CNT_W'(LAT - 1);
          owner_nx  = gnt1;
          valid_nx  = 1'b1;
          addr_nx   = gnt1 ? bif.m1_addr   : bif.m0_addr;
          wdata_nx  = gnt1 ? bif.m1_wdata  : bif.m0_wdata;
          byteen_nx = gnt1 ? bif.m1_byteen : bif.m0_byteen;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          // last bus cycle: hand read data to the owner and release the bus
          state_nx  = IDLE;
          valid_nx  = 1'b0;
          addr_nx   = '0;
          wdata_nx  = '0;
          byteen_nx = '0;
          if (owner == M1) begin
            rdata1_nx  = bif.bus_rdata;
            rvalid1_nx = 1'b1;
          end else begin
            rdata0_nx  = bif.bus_rdata;
            rvalid0_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bif.m0_gnt     = gnt0;
  assign bif.m1_gnt     = gnt1;
  assign bif.m0_rvalid  = rvalid0_q;
  assign bif.m1_rvalid  = rvalid1_q;
  assign bif.m0_rdata   = rdata0_q;
  assign bif.m1_rdata   = rdata1_q;
  assign bif.bus_valid  = valid_q;
  assign bif.bus_addr   = addr_q;
  assign bif.bus_wdata  = wdata_q;
  assign bif.bus_byteen = byteen_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run against a
// cycle-number based transaction model. Honours BUS_ARB_RR_EN when defined.
module tb_bus_arbiter;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  bus_arbiter_if ia();
  bus_arbiter_if ib();

  bus_arbiter #(.LAT(LAT_A), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bif(ia.slave));
  bus_arbiter #(.LAT(LAT_B), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bif(ib.slave));

  always #5 clk = ~clk;

  task automatic drive_idle();
    ia.m0_req = 0; ia.m0_addr = '0; ia.m0_wdata = '0; ia.m0_byteen = '0;
    ia.m1_req = 0; ia.m1_addr = '0; ia.m1_wdata = '0; ia.m1_byteen = '0;
    ia.bus_rdata = '0;
    ib.m0_req = 0; ib.m0_addr = '0; ib.m0_wdata = '0; ib.m0_byteen = '0;
    ib.m1_req = 0; ib.m1_addr = '0; ib.m1_wdata = '0; ib.m1_byteen = '0;
    ib.bus_rdata = '0;
  endtask

  // leaves the bench at posedge+1 with reset released
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ia.m0_req = 1; ia.m1_req = 1; ib.m0_req = 1; ib.m1_req = 1;
    #1;
    checks++;
    if ({ia.m0_gnt, ia.m1_gnt, ib.m0_gnt, ib.m1_gnt} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt got %b exp 0000", {ia.m0_gnt, ia.m1_gnt, ib.m0_gnt, ib.m1_gnt});
    end
    checks++;
    if ({ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen} !== 69'd0) begin
      errors++; $display("FAIL reset_bus got %h exp 0", {ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen});
    end
    checks++;
    if ({ia.m0_rvalid, ia.m1_rvalid, ia.m0_rdata, ia.m1_rdata} !== 66'd0) begin
      errors++; $display("FAIL reset_resp got %h exp 0", {ia.m0_rvalid, ia.m1_rvalid, ia.m0_rdata, ia.m1_rdata});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    // first tie after reset goes to M0 in both modes
    checks++;
    if ({ia.m0_gnt, ia.m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL reset_first_tie got %b exp 10", {ia.m0_gnt, ia.m1_gnt});
    end
    drive_idle();
  endtask

  task automatic test_lat1_read();
    apply_reset();
    ib.m0_req = 1; ib.m0_addr = 32'h0000_0010; ib.m0_byteen = 4'h0; ib.bus_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({ib.m0_gnt, ib.m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL lat1_gnt got %b exp 10", {ib.m0_gnt, ib.m1_gnt});
    end
    @(posedge clk); #1;
    ib.m0_req = 0;
    #1;
    checks++;
    if ({ib.bus_valid, ib.bus_addr, ib.bus_byteen, ib.m0_rvalid} !== {1'b1, 32'h0000_0010, 4'h0, 1'b0}) begin
      errors++; $display("FAIL lat1_bus got %h exp %h", {ib.bus_valid, ib.bus_addr, ib.bus_byteen, ib.m0_rvalid},
                         {1'b1, 32'h0000_0010, 4'h0, 1'b0});
    end
    @(posedge clk); #1; #1;
    checks++;
    if ({ib.m0_rvalid, ib.m1_rvalid, ib.bus_valid, ib.m0_rdata} !== {3'b100, 32'h1234_5678}) begin
      errors++; $display("FAIL lat1_rvalid got %h exp %h", {ib.m0_rvalid, ib.m1_rvalid, ib.bus_valid, ib.m0_rdata},
                         {3'b100, 32'h1234_5678});
    end
    ib.bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; #1;
    checks++;
    if ({ib.m0_rvalid, ib.m0_rdata} !== {1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL lat1_hold got %h exp %h", {ib.m0_rvalid, ib.m0_rdata}, {1'b0, 32'h1234_5678});
    end
    drive_idle();
  endtask

  task automatic test_write_lat3();
    apply_reset();
    ia.m1_req = 1; ia.m1_addr = 32'h0000_7F00; ia.m1_wdata = 32'hA5A5_A5A5; ia.m1_byteen = 4'hF;
    #1;
    checks++;
    if ({ia.m0_gnt, ia.m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL wr_gnt got %b exp 01", {ia.m0_gnt, ia.m1_gnt});
    end
    for (int c = 1; c <= LAT_A; c++) begin
      @(posedge clk); #1;
      ia.m1_req = 0; ia.m1_addr = 32'h1111_1111; ia.m1_byteen = 4'h0;
      #1;
      checks++;
      if ({ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen, ia.m1_rvalid} !==
          {1'b1, 32'h0000_7F00, 32'hA5A5_A5A5, 4'hF, 1'b0}) begin
        errors++; $display("FAIL wr_bus_c%0d got %h", c, {ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen, ia.m1_rvalid});
      end
    end
    @(posedge clk); #1; #1;
    checks++;
    if ({ia.m1_rvalid, ia.m0_rvalid, ia.bus_valid, ia.bus_byteen} !== 7'b100_0000) begin
      errors++; $display("FAIL wr_done got %b exp 1000000", {ia.m1_rvalid, ia.m0_rvalid, ia.bus_valid, ia.bus_byteen});
    end
    @(posedge clk); #1; #1;
    checks++;
    if (ia.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse got %b exp 0", ia.m1_rvalid);
    end
    drive_idle();
  endtask

  task automatic test_both_held();
    logic [1:0] exp_g;
    int k;
    apply_reset();
    ia.m0_req = 1; ia.m0_addr = 32'h100; ia.m1_req = 1; ia.m1_addr = 32'h200;
    k = 0;
    for (int t = 0; t < 4 * (LAT_A + 1); t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      #1;
      if (t % (LAT_A + 1) == 0) begin
        exp_g = (RR && (k % 2 == 1)) ? 2'b01 : 2'b10;
        k++;
      end else begin
        exp_g = 2'b00;
      end
      checks++;
      if ({ia.m0_gnt, ia.m1_gnt} !== exp_g) begin
        errors++; $display("FAIL both_held_t%0d got %b exp %b", t, {ia.m0_gnt, ia.m1_gnt}, exp_g);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_busy();
    apply_reset();
    ia.m0_req = 1; ia.m0_addr = 32'h40; ia.m0_byteen = 4'h0;
    #1;
    checks++;
    if (ia.m0_gnt !== 1'b1) begin
      errors++; $display("FAIL rb_gnt got %b exp 1", ia.m0_gnt);
    end
    @(posedge clk); #1;
    ia.m0_req = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    ia.m0_req = 1;
    #1;
    checks++;
    if ({ia.bus_valid, ia.bus_addr, ia.bus_byteen, ia.m0_gnt, ia.m0_rvalid} !== 39'd0) begin
      errors++; $display("FAIL rb_abandon got %h exp 0", {ia.bus_valid, ia.bus_addr, ia.bus_byteen, ia.m0_gnt, ia.m0_rvalid});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ia.m0_addr = 32'h44;
    #1;
    checks++;
    if ({ia.m0_gnt, ia.m0_rvalid} !== 2'b10) begin
      errors++; $display("FAIL rb_regrant got %b exp 10", {ia.m0_gnt, ia.m0_rvalid});
    end
    for (int c = 1; c <= LAT_A; c++) begin
      @(posedge clk); #1;
      ia.m0_req = 0;
      #1;
      checks++;
      if ({ia.m0_rvalid, ia.bus_valid, ia.bus_addr} !== {2'b01, 32'h44}) begin
        errors++; $display("FAIL rb_after_c%0d got %h exp %h", c, {ia.m0_rvalid, ia.bus_valid, ia.bus_addr}, {2'b01, 32'h44});
      end
    end
    drive_idle();
  endtask

  // Transaction model: a grant at cycle g owns the bus for cycles g+1..g+LAT_A and
  // completes with rvalid at g+LAT_A+1; the bus is free again from g+LAT_A+1 on.
  task automatic test_random();
    int g, w;
    logic own, last;
    logic [31:0] la, lw, rd;
    logic [3:0] lb;
    logic [31:0] er[2];
    logic mreq[2], got[2];
    logic [31:0] maddr[2], mwd[2];
    logic [3:0] mbe[2];
    logic [68:0] eb;
    logic [1:0] eg, erv;
    apply_reset();
    g = -1000; own = 1'b0; last = 1'b1;
    la = '0; lw = '0; lb = '0;
    er[0] = '0; er[1] = '0;
    mreq = '{1'b0, 1'b0}; got = '{1'b0, 1'b0};
    maddr = '{32'd0, 32'd0}; mwd = '{32'd0, 32'd0}; mbe = '{4'd0, 4'd0};
    for (int t = 0; t < 600; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      for (int m = 0; m < 2; m++) begin
        if (!mreq[m] || got[m]) begin
          mreq[m]  = ($urandom_range(0, 2) != 0);
          maddr[m] = $urandom();
          mwd[m]   = $urandom();
          mbe[m]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
        end else if ($urandom_range(0, 15) == 0) begin
          mreq[m] = 1'b0;
        end
      end
      rd = $urandom();
      ia.m0_req = mreq[0]; ia.m0_addr = maddr[0]; ia.m0_wdata = mwd[0]; ia.m0_byteen = mbe[0];
      ia.m1_req = mreq[1]; ia.m1_addr = maddr[1]; ia.m1_wdata = mwd[1]; ia.m1_byteen = mbe[1];
      ia.bus_rdata = rd;
      #1;
      eb  = (t >= g + 1 && t <= g + LAT_A) ? {1'b1, la, lw, lb} : 69'd0;
      erv = (t == g + LAT_A + 1) ? (own ? 2'b01 : 2'b10) : 2'b00;
      w = -1;
      if (t > g + LAT_A) begin
        if (mreq[0] && mreq[1]) w = (RR && !last) ? 1 : 0;
        else if (mreq[0])       w = 0;
        else if (mreq[1])       w = 1;
      end
      eg = (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
      checks++;
      if ({ia.m0_gnt, ia.m1_gnt} !== eg) begin
        errors++; $display("FAIL rnd_gnt t=%0d got %b exp %b", t, {ia.m0_gnt, ia.m1_gnt}, eg);
      end
      checks++;
      if ({ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen} !== eb) begin
        errors++; $display("FAIL rnd_bus t=%0d got %h exp %h", t, {ia.bus_valid, ia.bus_addr, ia.bus_wdata, ia.bus_byteen}, eb);
      end
      checks++;
      if ({ia.m0_rvalid, ia.m1_rvalid} !== erv) begin
        errors++; $display("FAIL rnd_rvalid t=%0d got %b exp %b", t, {ia.m0_rvalid, ia.m1_rvalid}, erv);
      end
      checks++;
      if ({ia.m0_rdata, ia.m1_rdata} !== {er[0], er[1]}) begin
        errors++; $display("FAIL rnd_rdata t=%0d got %h exp %h", t, {ia.m0_rdata, ia.m1_rdata}, {er[0], er[1]});
      end
      if (t == g + LAT_A) er[own] = rd;
      got[0] = (w == 0);
      got[1] = (w == 1);
      if (w >= 0) begin
        g = t; own = (w == 1); last = own;
        la = maddr[w]; lw = mwd[w]; lb = mbe[w];
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_lat1_read();
    test_write_lat3();
    test_both_held();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
